reduce_seq_ctrl: RTL and testbench
==================================

// Module: reduce_seq_ctrl
// PURPOSE
//  Sequencer that applies a 4-bit unary reduction (AND/NAND/OR/NOR/XOR/XNOR)
//  across a wide operand, one CHUNK_W slice per cycle, and folds the slices
//  into one result bit. It sits between a valid/ready request source and a
//  consumer, so wide reductions time-share a single narrow reduction datapath.
// PARAMETERS
//  DATA_W   32  operand width; must be an integer multiple of CHUNK_W
//  CHUNK_W  4   slice width reduced per cycle
//  (NCHUNK = DATA_W/CHUNK_W is derived; elaboration fails if DATA_W%CHUNK_W!=0)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       request present
//  in_ready   out  1       controller can accept a request
//  in_data    in   DATA_W  operand
//  in_op      in   3       0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
//  out_valid  out  1       result present
//  out_ready  in   1       consumer takes the result
//  out_bit    out  1       reduction result
//  out_err    out  1       request carried an illegal op
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - One clock, synchronous active-high reset.
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_bit=0, out_err=0,
//    busy=0. Internal idx=0 and acc=0.
//  - FSM states are IDLE, RUN and DONE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data and in_op.
//    Legal op: load acc with the identity (1 for AND/NAND, 0 otherwise),
//    set idx=0 and go to RUN. Illegal op: go to DONE with out_bit=0, out_err=1.
//  - RUN: in_ready=0. Each cycle, acc <= acc OP reduce(slice[idx]), where
//    slice[idx] = data[idx*CHUNK_W +: CHUNK_W] and idx counts 0..NCHUNK-1
//    (LSB slice first). On idx==NCHUNK-1, go to DONE and register
//    out_bit = final acc, inverted for NAND/NOR/XNOR. out_err=0.
//  - Latency: out_valid rises exactly NCHUNK+1 cycles after the accepting
//    edge for a legal op, and 1 cycle after it for an illegal op.
//  - DONE: out_valid=1. out_bit and out_err hold stable until out_ready=1.
//    On the handshake edge, go to IDLE and clear out_valid. out_bit and
//    out_err keep their last value.
//  - No new request is accepted while a result is pending. in_ready is first
//    high again in the cycle after the out_ready handshake (no bypass).
//  - The latched operand is immune to in_data/in_op changes after acceptance.
//  - in_valid while busy is ignored; the source must hold it until accepted.
//  - rst asserted in any state, including mid-RUN or with a pending result:
//    the next edge returns all outputs to their reset values and discards
//    the in-flight request. No result is emitted for it.
//  - idx never wraps. RUN exits on the final slice, and idx is reloaded on
//    accept.
// TESTING (DATA_W=32, CHUNK_W=4, NCHUNK=8)
//  1 in_data=32'hFFFF_FFFF, op=AND, out_ready=1 -> out_valid high 9 cycles
//    after accept, out_bit=1, out_err=0; in_ready=1 the following cycle.
//  2 op sweep: 32'hFFFF_FFFE NAND->1; 32'h0000_0000 NOR->1; OR->0;
//    32'h8000_0001 XOR->0; 32'h0001_0000 XOR->1 and XNOR->0.
//  3 op=3'd7, any data -> out_valid 1 cycle after accept, out_err=1,
//    out_bit=0; a following legal request gives out_err=0.
//  4 backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_bit and
//    out_err stable; in_ready=0; a toggling in_valid is not accepted.
//  5 rst pulsed at RUN idx=4 -> next cycle state IDLE, in_ready=1,
//    out_valid=0. A new AND request of 32'hFFFF_FFFF completes normally (=1).
//  6 in_data changed every cycle during RUN -> result matches the operand
//    latched at accept; back-to-back requests lose no results.

Source files
------------

// File: rtl/reduce_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reduce_seq_ctrl
//
// Sequencer that applies a 4-bit unary reduction (AND/NAND/OR/NOR/XOR/XNOR)
// across a wide operand, one CHUNK_W slice per cycle, and folds the per-slice
// results into a single result bit. It sits between a valid/ready request
// source and a consumer, so that wide reductions time-share one narrow
// reduction datapath.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       request present
//   in_ready   out  1       controller can accept a request (state == IDLE)
//   in_data    in   DATA_W  operand
//   in_op      in   3       0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
//   out_valid  out  1       result present (state == DONE)
//   out_ready  in   1       consumer takes the result
//   out_bit    out  1       reduction result
//   out_err    out  1       request carried an illegal op
//   busy       out  1       state != IDLE
// -----------------------------------------------------------------------------
module reduce_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_err,
    output logic              busy
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // The operand must split into whole slices; refuse to elaborate otherwise.
    generate
        if ((DATA_W % CHUNK_W) != 0 || DATA_W < CHUNK_W) begin : g_bad_width
            $error("reduce_seq_ctrl: DATA_W must be a non-zero multiple of CHUNK_W");
        end
    endgenerate

    // Op encoding: bits [2:1] select the family (00 AND, 01 OR, 10 XOR,
    // 11 illegal), bit [0] selects the inverted form (NAND/NOR/XNOR).
    localparam logic [1:0] FAM_AND = 2'b00;
    localparam logic [1:0] FAM_OR  = 2'b01;
    localparam logic [1:0] FAM_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [DATA_W-1:0]  data_q,    data_d;
    logic [2:0]         op_q,      op_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic               acc_q,     acc_d;
    logic               out_bit_q, out_bit_d;
    logic               out_err_q, out_err_d;

    // Slice view of the latched operand, LSB slice at index 0.
    logic [CHUNK_W-1:0] slices [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign slices[gi] = data_q[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    logic [CHUNK_W-1:0] cur_slice;
    logic               slice_red;
    logic               acc_step;

    // Narrow shared datapath: reduce the current slice and fold into acc.
    always_comb begin
        cur_slice = slices[idx_q];
        slice_red = ^cur_slice;
        acc_step  = acc_q ^ slice_red;
        case (op_q[2:1])
            FAM_AND: begin
                slice_red = &cur_slice;
                acc_step  = acc_q & slice_red;
            end
            FAM_OR: begin
                slice_red = |cur_slice;
                acc_step  = acc_q | slice_red;
            end
            default: begin
                slice_red = ^cur_slice;
                acc_step  = acc_q ^ slice_red;
            end
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        op_d      = op_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        out_bit_d = out_bit_q;
        out_err_d = out_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    op_d   = in_op;
                    if (in_op[2:1] == FAM_BAD) begin
                        // Illegal op skips the datapath and reports at once.
                        out_bit_d = 1'b0;
                        out_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        // Identity element: 1 for the AND family, 0 otherwise.
                        acc_d   = (in_op[2:1] == FAM_AND);
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                acc_d = acc_step;
                if (idx_q == LAST_IDX) begin
                    out_bit_d = acc_step ^ op_q[0];
                    out_err_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                // Result and flags hold until the consumer takes them.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            acc_q     <= 1'b0;
            out_bit_q <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            out_bit_q <= out_bit_d;
            out_err_q <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_bit   = out_bit_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_reduce_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reduce_seq_ctrl
//
// Directed-vector bench for reduce_seq_ctrl (DATA_W=32, CHUNK_W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reduce_seq_ctrl;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic              out_err;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;

    reduce_seq_ctrl #(
        .DATA_W  (32),
        .CHUNK_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for the result, optionally hold off the consumer
    // for hold cycles (toggling in_valid meanwhile), then complete the
    // handshake and check the controller is back in IDLE.
    task automatic run_req(input string tag, input logic [31:0] data, input logic [2:0] op,
                           input logic exp_bit, input logic exp_err, input int exp_lat,
                           input int hold, input bit scramble);
        int cycles;
        check_eq({tag, ".rdy_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_op    = op;
        @(negedge clk);
        in_valid = 1'b0;
        cycles   = 1;
        while (!out_valid && cycles < 50) begin
            if (scramble) begin
                in_data = $urandom;
                in_op   = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, ".lat"}, 32'(cycles), 32'(exp_lat));
        check_eq({tag, ".bit"}, 32'(out_bit), 32'(exp_bit));
        check_eq({tag, ".err"}, 32'(out_err), 32'(exp_err));
        check_eq({tag, ".rdy_done"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            in_data  = 32'hFFFF_FFFF;
            in_op    = OP_AND;
            @(negedge clk);
            check_eq({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
            check_eq({tag, ".hold_bit"}, 32'(out_bit), 32'(exp_bit));
            check_eq({tag, ".hold_err"}, 32'(out_err), 32'(exp_err));
            check_eq({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ".vld_post"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".rdy_post"}, 32'(in_ready), 32'd1);
        check_eq({tag, ".busy_post"}, 32'(busy), 32'd0);
        check_eq({tag, ".bit_keep"}, 32'(out_bit), 32'(exp_bit));
        $display("[TB] %s data=%h op=%0d bit=%0b err=%0b lat=%0d", tag, data, op,
                 exp_bit, exp_err, cycles);
    endtask

    initial begin
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.out_bit", 32'(out_bit), 32'd0);
        check_eq("rst.out_err", 32'(out_err), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic AND, 9-cycle latency.
        run_req("and_ones", 32'hFFFF_FFFF, OP_AND, 1'b1, 1'b0, 9, 0, 1'b0);

        // 2: op sweep.
        run_req("nand_lsb0", 32'hFFFF_FFFE, OP_NAND, 1'b1, 1'b0, 9, 0, 1'b0);
        run_req("nor_zero",  32'h0000_0000, OP_NOR,  1'b1, 1'b0, 9, 0, 1'b0);
        run_req("or_zero",   32'h0000_0000, OP_OR,   1'b0, 1'b0, 9, 0, 1'b0);
        run_req("xor_ends",  32'h8000_0001, OP_XOR,  1'b0, 1'b0, 9, 0, 1'b0);
        run_req("xor_mid",   32'h0001_0000, OP_XOR,  1'b1, 1'b0, 9, 0, 1'b0);
        run_req("xnor_mid",  32'h0001_0000, OP_XNOR, 1'b0, 1'b0, 9, 0, 1'b0);

        // 3: illegal ops, then a legal one clears the error flag.
        run_req("ill_7", 32'hDEAD_BEEF, 3'd7, 1'b0, 1'b1, 1, 0, 1'b0);
        run_req("ill_6", 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 1, 0, 1'b0);
        run_req("or_after_ill", 32'h0000_0010, OP_OR, 1'b1, 1'b0, 9, 0, 1'b0);

        // 4: backpressure for 5 cycles with in_valid toggling.
        run_req("nand_bp", 32'h0000_0000, OP_NAND, 1'b1, 1'b0, 9, 5, 1'b0);

        // 5: reset in the middle of RUN (idx=4 is the 5th cycle after accept).
        check_eq("mid_rst.rdy_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        in_op    = OP_NOR;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_rst.busy_run", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst.busy", 32'(busy), 32'd0);
        check_eq("mid_rst.out_bit", 32'(out_bit), 32'd0);
        check_eq("mid_rst.out_err", 32'(out_err), 32'd0);
        cycles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) cycles++;
        end
        check_eq("mid_rst.no_result", 32'(cycles), 32'd0);
        $display("[TB] mid_rst reset at idx=4, no result emitted");
        run_req("and_after_rst", 32'hFFFF_FFFF, OP_AND, 1'b1, 1'b0, 9, 0, 1'b0);

        // 6: operand scrambled during RUN, back-to-back requests.
        run_req("scr_xor",  32'h1234_5678, OP_XOR,  1'b1, 1'b0, 9, 0, 1'b1);
        run_req("scr_nand", 32'hFFFF_FFFF, OP_NAND, 1'b0, 1'b0, 9, 0, 1'b1);
        run_req("scr_nor",  32'h0000_0100, OP_NOR,  1'b0, 1'b0, 9, 0, 1'b1);
        run_req("scr_xnor", 32'hF000_000F, OP_XNOR, 1'b1, 1'b0, 9, 0, 1'b1);
        run_req("scr_and",  32'h7FFF_FFFF, OP_AND,  1'b0, 1'b0, 9, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
